// File: rtl/pn_pkg.sv
// pn_pkg: shared types and defaults for the PN sequence controller.
//   W_DEF   : default maximum LFSR width
//   poly_t  : 16-bit polynomial word as read from the polynomial ROM
//   state_t : controller FSM states
package pn_pkg;
    localparam int W_DEF = 13;
    typedef logic [15:0] poly_t;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, READY, ERR} state_t;
endpackage

// File: rtl/pn_lfsr_core.sv
// pn_lfsr_core: LFSR state register with the n-bit masked step rule and seed compare.
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : force state to zero (restart)
//   load         : state <= seed masked to n bits
//   step         : state <= next LFSR value
//   n, poly, seed: degree, tap mask, seed
//   state        : current state (zero above bit n-1)
//   hit          : the next state equals the seed
module pn_lfsr_core
    import pn_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         step,
    input  logic [3:0]   n,
    input  logic [W-1:0] poly,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state,
    output logic         hit
);
    logic [W-1:0] mask;
    logic [W-1:0] nxt;
    logic         fb;

    // Shifting all-ones left by n leaves exactly the upper bits to clear;
    // n==W shifts everything out, giving a full-width mask.
    always_comb begin
        mask = ~({W{1'b1}} << n);
        fb   = ^(state & poly & mask);
        nxt  = {state[W-2:0], fb} & mask;
        hit  = nxt == (seed & mask);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= '0;
        else if (clr)
            state <= '0;
        else if (load)
            state <= seed & mask;
        else if (step)
            state <= nxt;
endmodule

// File: rtl/pn_seq_ctrl.sv
// pn_seq_ctrl: sequences polynomial fetch, config check, seeding and stepping of the PN LFSR.
//   clk, rst       : clock, asynchronous active-low reset
//   start          : latch num/init and (re)load
//   next           : single step pulse
//   run            : auto-step every AUTO_DIV clocks while high
//   num, init      : degree and seed
//   rom_addr       : polynomial ROM address (degree)
//   rom_data       : polynomial read back after ROM_LAT cycles
//   seq_out, valid : current LFSR state and its qualifier
//   busy           : fetch/load in progress
//   wrap, period   : return-to-seed pulse and last measured cycle length
//   err            : configuration rejected
module pn_seq_ctrl
    import pn_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int ROM_LAT  = 1,
    parameter int AUTO_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         next,
    input  logic         run,
    input  logic [3:0]   num,
    input  logic [W-1:0] init,
    output logic [3:0]   rom_addr,
    input  poly_t        rom_data,
    output logic [W-1:0] seq_out,
    output logic         valid,
    output logic         busy,
    output logic         wrap,
    output logic [W-1:0] period,
    output logic         err
);
    localparam int LW = $clog2(ROM_LAT + 1);
    localparam int DW = $clog2(AUTO_DIV);

    state_t       st;
    logic [3:0]   n_r;
    logic [W-1:0] seed_r;
    logic [W-1:0] poly_r;
    logic [W-1:0] cnt;
    logic [W-1:0] mask;
    logic [LW-1:0] lat;
    logic [DW-1:0] div;
    logic         restart;
    logic         cfg_ok;
    logic         tick;
    logic         step;
    logic         load;
    logic         hit;

    // start is honoured only outside FETCH/LOAD and always wins over a step.
    always_comb begin
        restart = start && (st == IDLE || st == READY || st == ERR);
        mask    = ~({W{1'b1}} << n_r);
        cfg_ok  = n_r >= 4'd2 && int'(n_r) <= W && (seed_r & mask) != '0 && rom_data[n_r - 4'd1];
        load    = st == LOAD && cfg_ok;
        tick    = run && div == DW'(AUTO_DIV - 1);
        step    = st == READY && !start && (next || tick);
    end

    pn_lfsr_core #(.W(W)) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .load  (load),
        .step  (step),
        .n     (n_r),
        .poly  (poly_r),
        .seed  (seed_r),
        .state (seq_out),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st       <= IDLE;
            n_r      <= '0;
            seed_r   <= '0;
            poly_r   <= '0;
            cnt      <= '0;
            lat      <= '0;
            div      <= '0;
            rom_addr <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            period   <= '0;
            err      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            // Divider only runs in READY with run high; anything else clears it.
            div  <= (st == READY && run && !tick) ? div + 1'b1 : '0;
            if (restart) begin
                st       <= FETCH;
                n_r      <= num;
                seed_r   <= init;
                lat      <= LW'(1);
                rom_addr <= num;
                valid    <= 1'b0;
                busy     <= 1'b1;
                err      <= 1'b0;
                period   <= '0;
            end else begin
                case (st)
                    FETCH:
                        if (lat == LW'(ROM_LAT)) begin
                            st       <= LOAD;
                            rom_addr <= '0;
                        end else
                            lat <= lat + 1'b1;
                    LOAD: begin
                        poly_r <= rom_data[W-1:0];
                        busy   <= 1'b0;
                        cnt    <= '0;
                        period <= '0;
                        st     <= cfg_ok ? READY : ERR;
                        valid  <= cfg_ok;
                        err    <= !cfg_ok;
                    end
                    READY:
                        if (step) begin
                            if (hit) begin
                                wrap   <= 1'b1;
                                period <= cnt + 1'b1;
                                cnt    <= '0;
                            end else
                                cnt <= cnt + 1'b1;
                        end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_pn_seq_ctrl.sv
// tb_pn_seq_ctrl: directed and randomized checks of pn_seq_ctrl against an arithmetic LFSR model.
module tb_pn_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic        next;
    logic        run;
    logic [3:0]  num;
    logic [12:0] init;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [12:0] seq_out;
    logic        valid;
    logic        busy;
    logic        wrap;
    logic [12:0] period;
    logic        err;

    logic [15:0] rom [16];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ms, cnt_m, per_m, rl, nwrap, nd, sd;
    bit          ew, nx, rn, stp;
    logic [15:0] p;
    logic [12:0] exp5 [5] = '{13'h2, 13'h4, 13'h9, 13'h3, 13'h6};
    int          rej_n [4] = '{1, 14, 4, 5};
    int          rej_s [4] = '{1, 1, 0, 1};

    pn_seq_ctrl #(.W(13), .ROM_LAT(1), .AUTO_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .next     (next),
        .run      (run),
        .num      (num),
        .init     (init),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .seq_out  (seq_out),
        .valid    (valid),
        .busy     (busy),
        .wrap     (wrap),
        .period   (period),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_seq"}, 32'(seq_out), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wrap"}, 32'(wrap), 0);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_addr"}, 32'(rom_addr), 0);
    endtask

    task automatic do_start(input int n, input int s, input bit nx_in);
        start = 1'b1;
        num   = 4'(n);
        init  = 13'(s);
        next  = nx_in;
        @(negedge clk);
        start = 1'b0;
        next  = 1'b0;
    endtask

    function automatic int mdl_next(input int s, input int pv, input int n);
        int par = 0;
        for (int i = 0; i < n; i++) par += ((s >> i) & 1) * ((pv >> i) & 1);
        return (s * 2 + par % 2) % (1 << n);
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; next = 1'b0; run = 1'b0; num = '0; init = '0; rom_data = '0;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[4]  = 16'h000C;
        rom[5]  = 16'h0003;
        rom[13] = 16'h1B00;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // Degree 4 walk and wrap.
        do_start(4, 1, 0);
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_addr", 32'(rom_addr), 4);
        chk("fetch_valid", 32'(valid), 0);
        @(negedge clk);
        chk("load_busy", 32'(busy), 1);
        chk("load_valid", 32'(valid), 0);
        @(negedge clk);
        chk("ready_valid", 32'(valid), 1);
        chk("ready_busy", 32'(busy), 0);
        chk("ready_seed", 32'(seq_out), 1);
        for (int i = 0; i < 5; i++) begin
            next = 1'b1;
            @(negedge clk);
            next = 1'b0;
            chk("d4_step", 32'(seq_out), 32'(exp5[i]));
            chk("d4_nowrap", 32'(wrap), 0);
        end
        for (int i = 6; i <= 15; i++) begin
            next = 1'b1;
            @(negedge clk);
            next = 1'b0;
            chk("d4_wrap", 32'(wrap), 32'(i == 15));
        end
        chk("d4_wrap_seq", 32'(seq_out), 1);
        chk("d4_period", 32'(period), 15);
        @(negedge clk);
        chk("d4_wrap_pulse", 32'(wrap), 0);
        chk("d4_period_hold", 32'(period), 15);

        // Rejections, then recovery.
        for (int k = 0; k < 4; k++) begin
            do_start(rej_n[k], rej_s[k], 0);
            chk("rej_fetch_err", 32'(err), 0);
            repeat (2) @(negedge clk);
            chk("rej_err", 32'(err), 1);
            chk("rej_valid", 32'(valid), 0);
            chk("rej_seq", 32'(seq_out), 0);
        end
        do_start(4, 1, 0);
        chk("recover_err_clr", 32'(err), 0);
        repeat (2) @(negedge clk);
        chk("recover_valid", 32'(valid), 1);
        chk("recover_seq", 32'(seq_out), 1);

        // Auto-run with AUTO_DIV=4.
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("auto_seq", 32'(seq_out), k < 4 ? 1 : (k < 8 ? 2 : 4));
        end
        run = 1'b0;
        repeat (4) @(negedge clk);
        chk("auto_stop", 32'(seq_out), 4);

        // next during FETCH is dropped.
        do_start(4, 1, 0);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        @(negedge clk);
        chk("fetch_next_seq", 32'(seq_out), 1);
        @(negedge clk);
        chk("fetch_next_noqueue", 32'(seq_out), 1);

        // start beats a same-cycle next.
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        chk("pre_restart", 32'(seq_out), 2);
        do_start(4, 1, 1);
        chk("restart_valid", 32'(valid), 0);
        chk("restart_seq", 32'(seq_out), 0);
        repeat (2) @(negedge clk);
        chk("restart_seed", 32'(seq_out), 1);
        @(negedge clk);
        chk("restart_nostep", 32'(seq_out), 1);

        // Asynchronous reset mid-FETCH and mid-READY.
        do_start(4, 1, 0);
        rst = 1'b0;
        #1;
        chk_idle("rst_fetch");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("rst_fetch_idle");
        do_start(4, 1, 0);
        repeat (2) @(negedge clk);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        chk("rst_ready_pre", 32'(seq_out), 2);
        rst = 1'b0;
        #1;
        chk_idle("rst_ready");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("rst_ready_idle");

        // Randomized configurations against the model.
        for (int c = 0; c < 6; c++) begin
            nd = $urandom_range(2, 12);
            p  = 16'($urandom) | 16'(1 << (nd - 1));
            rom[nd] = p;
            sd = int'($urandom % ((1 << nd) - 1)) + 1;
            do_start(nd, sd, 0);
            repeat (2) @(negedge clk);
            chk("rnd_valid", 32'(valid), 1);
            chk("rnd_seed", 32'(seq_out), 32'(sd));
            ms = sd; cnt_m = 0; per_m = 0; rl = 0;
            for (int k = 0; k < 60; k++) begin
                nx = 1'($urandom_range(0, 1));
                rn = $urandom_range(0, 3) != 0;
                next = nx;
                run  = rn;
                rl   = rn ? rl + 1 : 0;
                stp  = nx || (rn && rl % 4 == 0);
                ew   = 1'b0;
                if (stp) begin
                    ms = mdl_next(ms, int'(p), nd);
                    cnt_m++;
                    if (ms == sd) begin
                        ew = 1'b1;
                        per_m = cnt_m;
                        cnt_m = 0;
                    end
                end
                @(negedge clk);
                chk("rnd_seq", 32'(seq_out), 32'(ms));
                chk("rnd_wrap", 32'(wrap), 32'(ew));
                chk("rnd_period", 32'(period), 32'(per_m));
            end
            next = 1'b0;
            run  = 1'b0;
        end

        // Full-length degree 13 sequence.
        do_start(13, 1, 0);
        repeat (2) @(negedge clk);
        chk("d13_valid", 32'(valid), 1);
        nwrap = 0;
        next = 1'b1;
        for (int i = 1; i <= 8191; i++) begin
            @(negedge clk);
            if (wrap) nwrap++;
        end
        next = 1'b0;
        chk("d13_wrap_last", 32'(wrap), 1);
        chk("d13_wrap_count", 32'(nwrap), 1);
        chk("d13_seq", 32'(seq_out), 1);
        chk("d13_period", 32'(period), 8191);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pn_seq_ctrl.md
# pn_seq_ctrl

Controller that sequences the PN generator datapath. On `start` it fetches the characteristic polynomial for the selected degree from the synchronous polynomial ROM, validates the configuration, and loads the seed. It then advances the LFSR on single-step pulses or at a programmable auto-run rate, and reports wrap-around and the measured period. It sits between the debounced front-panel pulses and the masking/BCD display path.

## Interface
- `W`, 13: maximum LFSR width; also the width of the seed, state and period count.
- `ROM_LAT`, 1: read latency of the polynomial ROM in cycles, ≥1.
- `AUTO_DIV`, 1000: clocks per auto-run step, ≥2.

- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; latch `num`/`init` and (re)load.
- `next` in 1: one-cycle pulse; advance one step.
- `run` in 1: level; auto-advance every `AUTO_DIV` clocks.
- `num` in 4: LFSR degree n, valid range 2..W.
- `init` in W: seed; only bits [n-1:0] are used.
- `rom_addr` out 4: polynomial ROM address.
- `rom_data` in 16: polynomial; bit i set = tap on state bit i.
- `seq_out` out W: current LFSR state, zero-extended above bit n-1.
- `valid` out 1: `seq_out` is a live sequence value.
- `busy` out 1: FETCH or LOAD in progress.
- `wrap` out 1: one-cycle pulse when the state returns to the seed.
- `period` out W: step count of the last completed cycle.
- `err` out 1: configuration rejected.

## Operation
- FSM states: IDLE, FETCH, LOAD, READY, ERR. Reset enters IDLE.
- IDLE: all outputs are 0. `start` → FETCH.
- FETCH:
  - Latch `num` and `init`.
  - Drive `rom_addr` = latched num for ROM_LAT cycles, then → LOAD.
  - `next` and `run` are ignored, not queued.
- LOAD:
  - Capture `rom_data`.
  - Reject to ERR if any of these hold: n<2, n>W, seed[n-1:0]==0, or poly bit n-1 clear.
  - Otherwise: state = seed[n-1:0], step_cnt = 0, clear the auto-run divider, → READY.
- READY: `valid`=1. A step occurs on `next`, or on an auto tick while `run`=1. If both arrive in the same cycle, exactly one step is taken.
- Step rule, masked to n bits:
  - fb = XOR(state & poly[n-1:0])
  - state' = ((state<<1) | fb) & (2^n−1)
  - step_cnt' = step_cnt+1
- Wrap: if state' equals the seed, then `wrap` pulses, `period` = step_cnt+1, and step_cnt = 0. `period` holds its value until the next wrap or load.
- `start` in READY or ERR → FETCH. `valid` drops the next cycle, and `seq_out`/`period` are cleared. `start` beats a same-cycle `next`.
- ERR: `err`=1, `valid`=0. Exit only via `start`.
- `rst` asserted at any point returns immediately to IDLE with all outputs at 0.

## Timing
- `start` sampled at cycle t:
  - FETCH spans t+1..t+ROM_LAT.
  - LOAD at t+ROM_LAT+1.
  - READY with `valid`=1 and `seq_out`=seed at t+ROM_LAT+2 (t+3 for the default).
  - On rejection, `err`=1 at t+ROM_LAT+2 instead.
- `busy`=1 exactly during FETCH and LOAD.
- `next` at cycle t in READY → new `seq_out` at t+1. `wrap` and `period` are registered in the same edge as the state.
- Auto-run:
  - The first step occurs AUTO_DIV cycles after `run` rises in READY, then every AUTO_DIV cycles.
  - Deasserting `run` clears the divider.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `pn_pkg`: FSM state enum, `W` default, and a `poly_t` 16-bit typedef.
- Sub-module `pn_lfsr_core`: holds the state register and the step/mask/compare-to-seed logic. It takes load, step, n, poly and seed as inputs and produces state and hit.
- The FSM, ROM wait counter, auto divider and period counter live in `pn_seq_ctrl`.

## Test plan
- Degree 4, poly 0x000C, seed 0x1, five `next` pulses:
  - `seq_out` = 0x1 → 0x2 → 0x4 → 0x9 → 0x3 → 0x6.
  - `valid` first seen 3 cycles after `start`.
- Same configuration, 15 `next` pulses: `wrap` pulses once on step 15, `seq_out`=0x1, `period`=15.
- Rejection cases: num=1, num=14, seed 0x0, and a poly with bit n-1 clear each give `err`=1 at t+3. `start` with a valid configuration clears `err`.
- Degree 4 with `run`=1 and AUTO_DIV=4: steps occur every 4 cycles. `next` pulses during FETCH are ignored. Same-cycle `start`+`next` reloads without stepping.
- `rst` low mid-FETCH and mid-READY: all outputs are 0 asynchronously. After release the FSM stays in IDLE until `start`.
- Degree 13, poly 0x1B00 (x^13+x^12+x^10+x^9+1), 8191 steps: `period`=8191 and `wrap` occurs once.
